irq_controller: RTL

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// irq_controller: interrupt flag/enable/master-enable registers, edge-detected
// level sources, and a RUN/HALT/STOP power-state FSM driving the CPU clock gate.
// Optional keypad interrupt logic is built when KEYPAD_IRQ_EN is defined.
module irq_controller (
    input  logic        clk_mem,
    input  logic        rst,
    input  logic [23:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  width,
    input  logic [13:0] irq_src,
    input  logic [9:0]  keys,
    output logic        irq,
    output logic        halt
);

    // Word indices (addr[11:2]) of the decoded registers
    localparam logic [9:0]  WordIrq      = 10'h080;  // 0x200: {IF, IE}
    localparam logic [9:0]  WordIme      = 10'h082;  // 0x208: IME
    localparam logic [9:0]  WordKey      = 10'h04C;  // 0x130: {KEYCNT, keys}
    localparam logic [9:0]  WordPow      = 10'h0C0;  // 0x300: HALTCNT in byte 1
    // Sources able to leave STOP: cartridge (13), keypad (12), serial (7)
    localparam logic [13:0] StopWakeMask = 14'h3080;

    typedef enum logic [1:0] {
        StRun,
        StHalt,
        StStop
    } state_e;

    logic [4:0]  shift;
    logic [9:0]  word_sel;
    logic [31:0] mask_raw;
    logic [31:0] wmask;
    logic [31:0] wdata;
    logic        wr_irq;
    logic        wr_ime;
    logic        wr_key;
    logic        wr_pow;

    logic [13:0] ie_q, ie_d;
    logic [13:0] if_q, if_d;
    logic [13:0] if_clr;
    logic [13:0] if_set;
    logic [13:0] prev_q;
    logic        ime_q, ime_d;
    logic        irq_q;
    logic [13:0] pending;

    state_e      state_q, state_d;
    logic        halt_q;

    logic [15:0] keycnt_rd;
    logic        key_rise;
    logic [31:0] rd_word;

    logic        unused;

    // Strobe and upper address bits carry no function; lanes outside fields are ignored
    assign unused = ^{read, addr[23:12], wmask, wdata};

    assign shift    = {addr[1:0], 3'b000};
    assign word_sel = addr[11:2];

    // Byte-lane mask of the access before alignment
    always_comb begin
        case (width)
            2'b00:   mask_raw = 32'h0000_00ff;
            2'b01:   mask_raw = 32'h0000_ffff;
            default: mask_raw = 32'hffff_ffff;
        endcase
    end

    assign wmask  = mask_raw << shift;
    assign wdata  = (data_in << shift) & wmask;
    assign wr_irq = write & (word_sel == WordIrq);
    assign wr_ime = write & (word_sel == WordIme);
    assign wr_key = write & (word_sel == WordKey);
    assign wr_pow = write & (word_sel == WordPow) & wmask[8];

    assign pending = ie_q & if_q;

`ifdef KEYPAD_IRQ_EN
    logic [9:0] key_sel_q;
    logic       key_en_q;
    logic       key_mode_q;
    logic       key_prev_q;
    logic [9:0] key_hit;
    logic       key_cond;

    // Selected keys that are currently pressed (keys are active-low)
    assign key_hit  = ~keys & key_sel_q;
    // AND mode needs every selected key down; empty selection never fires
    assign key_cond = key_en_q & (key_sel_q != 10'h0) &
                      (key_mode_q ? (key_hit == key_sel_q) : (key_hit != 10'h0));
    assign key_rise = key_cond & ~key_prev_q;
    assign keycnt_rd = {key_mode_q, key_en_q, 4'h0, key_sel_q};

    // KEYCNT register (upper half of word 0x130) and key_cond edge history
    always_ff @(posedge clk_mem or posedge rst) begin
        if (rst) begin
            key_sel_q  <= '0;
            key_en_q   <= 1'b0;
            key_mode_q <= 1'b0;
            key_prev_q <= 1'b0;
        end else begin
            key_prev_q <= key_cond;
            if (wr_key) begin
                key_sel_q <= (key_sel_q & ~wmask[25:16]) | (wdata[25:16] & wmask[25:16]);
                if (wmask[30]) key_en_q <= wdata[30];
                if (wmask[31]) key_mode_q <= wdata[31];
            end
        end
    end
`else
    logic unused_key;

    assign unused_key = wr_key;
    assign key_rise   = 1'b0;
    assign keycnt_rd  = 16'h0;
`endif

    // Next-state of IE, IME and IF; a same-cycle set overrides a clear
    always_comb begin
        ie_d   = ie_q;
        ime_d  = ime_q;
        if_clr = '0;
        if (wr_irq) begin
            ie_d   = (ie_q & ~wmask[13:0]) | wdata[13:0];
            if_clr = wdata[29:16];
        end
        if (wr_ime && wmask[0]) begin
            ime_d = wdata[0];
        end
        if_set     = irq_src & ~prev_q;
        if_set[12] = if_set[12] | key_rise;
        if_d       = (if_q & ~if_clr) | if_set;
    end

    // Interrupt registers, source edge history and the registered request
    always_ff @(posedge clk_mem or posedge rst) begin
        if (rst) begin
            ie_q   <= '0;
            if_q   <= '0;
            ime_q  <= 1'b0;
            prev_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            ie_q   <= ie_d;
            if_q   <= if_d;
            ime_q  <= ime_d;
            prev_q <= irq_src;
            irq_q  <= ime_q & (pending != 14'h0);
        end
    end

    assign irq = irq_q;

    // Power FSM next state; HALT wakes on any enabled flag regardless of IME
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (wr_pow) state_d = wdata[15] ? StStop : StHalt;
            end
            StHalt: begin
                if (pending != 14'h0) state_d = StRun;
            end
            StStop: begin
                if ((pending & StopWakeMask) != 14'h0) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // State register; halt decodes the next state so it tracks state_q exactly
    always_ff @(posedge clk_mem or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= (state_d != StRun);
        end
    end

    assign halt = halt_q;

    // Combinational read path, right-aligned to the byte offset
    always_comb begin
        rd_word = 32'h0;
        case (word_sel)
            WordIrq: rd_word = {2'b00, if_q, 2'b00, ie_q};
            WordIme: rd_word = {31'h0, ime_q};
            WordKey: rd_word = {keycnt_rd, 6'h0, keys};
            default: rd_word = 32'h0;
        endcase
        data_out = rd_word >> shift;
    end

endmodule
